// File: rtl/fpro_arb_pkg.sv
// Shared constants and FSM state type for the FPro MMIO bus arbiter.
package fpro_arb_pkg;

  localparam int ADDR_W    = 21;
  localparam int DATA_W    = 32;
  localparam int MAX_MST   = 4;
  localparam int MST_IDX_W = $clog2(MAX_MST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/fpro_rr_picker.sv
// Combinational round-robin picker: the first requester after last_i (mod N) wins.
module fpro_rr_picker
  import fpro_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]         req_i,
  input  logic [MST_IDX_W-1:0] last_i,
  output logic [N-1:0]         gnt_o,
  output logic [MST_IDX_W-1:0] idx_o,
  output logic                 vld_o
);

  logic [31:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    cand  = '0;
    // Walk candidates in priority order; the inner compare keeps every index constant.
    for (int unsigned k = 1; k <= N; k++) begin
      cand = (32'(last_i) + k) % 32'(N);
      for (int unsigned i = 0; i < N; i++) begin
        if (!vld_o && req_i[i] && (i == cand)) begin
          vld_o    = 1'b1;
          gnt_o[i] = 1'b1;
          idx_o    = MST_IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/fpro_bus_arbiter.sv
// Round-robin arbiter sharing the FPro MMIO bus between up to four masters,
// with registered strobes, captured read data and an optional bus lock.
module fpro_bus_arbiter
  import fpro_arb_pkg::*;
#(
  parameter int N_MST = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_MST-1:0]              m_req,
  input  logic [N_MST-1:0]              m_wr,
  input  logic [N_MST-1:0]              m_lock,
  input  logic [N_MST-1:0][ADDR_W-1:0]  m_addr,
  input  logic [N_MST-1:0][DATA_W-1:0]  m_wr_data,
  output logic [N_MST-1:0]              m_ack,
  output logic [DATA_W-1:0]             m_rd_data,
  output logic                          mmio_cs,
  output logic                          mmio_rd,
  output logic                          mmio_wr,
  output logic [ADDR_W-1:0]             mmio_addr,
  output logic [DATA_W-1:0]             mmio_wr_data,
  input  logic [DATA_W-1:0]             mmio_rd_data
);

  localparam logic [MST_IDX_W-1:0] LAST_RST = MST_IDX_W'(N_MST - 1);

  arb_state_e             state_q, state_d;
  logic [MST_IDX_W-1:0]   last_q, last_d;
  logic [N_MST-1:0]       win_q, win_d;
  logic [N_MST-1:0]       owner_q, owner_d;
  logic                   lock_q, lock_d;
  logic                   ltxn_q, ltxn_d;
  logic                   cs_q, cs_d;
  logic                   rd_q, rd_d;
  logic                   wr_q, wr_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [N_MST-1:0]       ack_q, ack_d;
  logic [DATA_W-1:0]      rdbuf_q, rdbuf_d;

  logic [N_MST-1:0]       req_eff;
  logic [N_MST-1:0]       pick_gnt;
  logic [MST_IDX_W-1:0]   pick_idx;
  logic                   pick_vld;

  logic                   sel_wr;
  logic                   sel_lock;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_wdata;

  // A held lock masks every requester except the owner.
  assign req_eff = lock_q ? (m_req & owner_q) : m_req;

  fpro_rr_picker #(
    .N (N_MST)
  ) u_picker (
    .req_i  (req_eff),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .vld_o  (pick_vld)
  );

  always_comb begin
    sel_wr    = 1'b0;
    sel_lock  = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < N_MST; i++) begin
      if (pick_gnt[i]) begin
        sel_wr    = m_wr[i];
        sel_lock  = m_lock[i];
        sel_addr  = m_addr[i];
        sel_wdata = m_wr_data[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    owner_d = owner_q;
    lock_d  = lock_q;
    ltxn_d  = ltxn_q;
    cs_d    = 1'b0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ack_d   = '0;
    rdbuf_d = rdbuf_q;

    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = ISSUE;
          last_d  = pick_idx;
          win_d   = pick_gnt;
          ltxn_d  = sel_lock;
          cs_d    = 1'b1;
          rd_d    = ~sel_wr;
          wr_d    = sel_wr;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          if (sel_lock) begin
            lock_d  = 1'b1;
            owner_d = pick_gnt;
          end
        end
      end
      ISSUE: begin
        state_d = ACK;
        ack_d   = win_q;
        if (rd_q) begin
          rdbuf_d = mmio_rd_data;
        end
      end
      ACK: begin
        state_d = IDLE;
        if (!ltxn_q) begin
          lock_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= LAST_RST;
      win_q   <= '0;
      owner_q <= '0;
      lock_q  <= 1'b0;
      ltxn_q  <= 1'b0;
      cs_q    <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= '0;
      rdbuf_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      owner_q <= owner_d;
      lock_q  <= lock_d;
      ltxn_q  <= ltxn_d;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      rdbuf_q <= rdbuf_d;
    end
  end

  assign mmio_cs      = cs_q;
  assign mmio_rd      = rd_q;
  assign mmio_wr      = wr_q;
  assign mmio_addr    = addr_q;
  assign mmio_wr_data = wdata_q;
  assign m_ack        = ack_q;
  assign m_rd_data    = rdbuf_q;

endmodule
